// File: rtl/key_debounce_repeat_if.sv
// key_debounce_repeat_if: raw push-button lines and their conditioned outputs.
//   KEY         raw buttons, active-low, asynchronous to the clock
//   KEY_LEVEL   debounced state, 1 = pressed
//   KEY_PRESS   1-cycle pulse on accepted press
//   KEY_RELEASE 1-cycle pulse on accepted release
//   KEY_REPEAT  1-cycle pulse per auto-repeat while held
// slave modport is the conditioner side; master modport is the board/consumer side.
interface key_debounce_repeat_if #(
    parameter int unsigned N_KEYS = 4
) ();

    logic [N_KEYS-1:0] KEY;
    logic [N_KEYS-1:0] KEY_LEVEL;
    logic [N_KEYS-1:0] KEY_PRESS;
    logic [N_KEYS-1:0] KEY_RELEASE;
    logic [N_KEYS-1:0] KEY_REPEAT;

    modport slave (
        input  KEY,
        output KEY_LEVEL,
        output KEY_PRESS,
        output KEY_RELEASE,
        output KEY_REPEAT
    );

    modport master (
        output KEY,
        input  KEY_LEVEL,
        input  KEY_PRESS,
        input  KEY_RELEASE,
        input  KEY_REPEAT
    );

endinterface

// File: rtl/key_debounce_repeat.sv
// key_debounce_repeat: synchronizes, debounces and auto-repeats the push-buttons.
// Every key is handled independently: a two-flop synchronizer, a stability
// counter that accepts a change after DEBOUNCE_CYCLES consecutive disagreeing
// samples, and a press/delay/repeat FSM producing single-cycle pulses.
//   CLOCK_50  single clock, rising edge
//   RESET_N   asynchronous active-low reset
//   kif       key_debounce_repeat_if.slave (KEY in; KEY_LEVEL/PRESS/RELEASE/REPEAT out)
module key_debounce_repeat #(
    parameter int unsigned N_KEYS          = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned REPEAT_DELAY    = 25_000_000,
    parameter int unsigned REPEAT_PERIOD   = 5_000_000
) (
    input  logic                   CLOCK_50,
    input  logic                   RESET_N,
    key_debounce_repeat_if.slave   kif
);

    localparam int unsigned DCNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned RMAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RCNT_W = $clog2(RMAX + 1);

    // Terminal values are compared one below target: the increment "would reach" the target.
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RCNT_W-1:0] RD_LAST   = RCNT_W'(REPEAT_DELAY - 1);
    localparam logic [RCNT_W-1:0] RP_LAST   = RCNT_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    logic [N_KEYS-1:0] s1_q;
    logic [N_KEYS-1:0] s2_q;
    logic [N_KEYS-1:0] stable_q;
    logic [N_KEYS-1:0] stable_d;
    logic [N_KEYS-1:0] accept_c;
    logic [N_KEYS-1:0] press_d;
    logic [N_KEYS-1:0] release_d;
    logic [N_KEYS-1:0] repeat_d;

    logic [DCNT_W-1:0] dcnt_q  [N_KEYS];
    logic [DCNT_W-1:0] dcnt_d  [N_KEYS];
    logic [RCNT_W-1:0] rcnt_q  [N_KEYS];
    logic [RCNT_W-1:0] rcnt_d  [N_KEYS];
    state_t            state_q [N_KEYS];
    state_t            state_d [N_KEYS];

    // State register: synchronizers, debounce, FSMs and registered outputs.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            s1_q            <= '1;
            s2_q            <= '1;
            stable_q        <= '1;
            kif.KEY_LEVEL   <= '0;
            kif.KEY_PRESS   <= '0;
            kif.KEY_RELEASE <= '0;
            kif.KEY_REPEAT  <= '0;
            for (int k = 0; k < N_KEYS; k++) begin
                dcnt_q[k]  <= '0;
                rcnt_q[k]  <= '0;
                state_q[k] <= ST_IDLE;
            end
        end else begin
            s1_q            <= kif.KEY;
            s2_q            <= s1_q;
            stable_q        <= stable_d;
            kif.KEY_LEVEL   <= ~stable_d;
            kif.KEY_PRESS   <= press_d;
            kif.KEY_RELEASE <= release_d;
            kif.KEY_REPEAT  <= repeat_d;
            for (int k = 0; k < N_KEYS; k++) begin
                dcnt_q[k]  <= dcnt_d[k];
                rcnt_q[k]  <= rcnt_d[k];
                state_q[k] <= state_d[k];
            end
        end
    end

    // Next-state: debounce acceptance feeds the FSM in the same cycle so
    // level and press/release pulses line up on the same edge.
    always_comb begin
        stable_d  = stable_q;
        accept_c  = '0;
        press_d   = '0;
        release_d = '0;
        repeat_d  = '0;
        for (int k = 0; k < N_KEYS; k++) begin
            dcnt_d[k]  = dcnt_q[k];
            rcnt_d[k]  = rcnt_q[k];
            state_d[k] = state_q[k];

            // Any agreeing sample restarts the count, rejecting glitches.
            if (s2_q[k] == stable_q[k]) begin
                dcnt_d[k] = '0;
            end else if (dcnt_q[k] == DCNT_LAST) begin
                dcnt_d[k]   = '0;
                stable_d[k] = s2_q[k];
                accept_c[k] = 1'b1;
            end else begin
                dcnt_d[k] = dcnt_q[k] + DCNT_W'(1);
            end

            // FSM state tracks stable: in IDLE an acceptance is a press, otherwise a release.
            case (state_q[k])
                ST_IDLE: begin
                    if (accept_c[k]) begin
                        press_d[k] = 1'b1;
                        rcnt_d[k]  = '0;
                        state_d[k] = ST_DELAY;
                    end
                end
                ST_DELAY: begin
                    if (accept_c[k]) begin
                        release_d[k] = 1'b1;
                        rcnt_d[k]    = '0;
                        state_d[k]   = ST_IDLE;
                    end else if (rcnt_q[k] == RD_LAST) begin
                        repeat_d[k] = 1'b1;
                        rcnt_d[k]   = '0;
                        state_d[k]  = ST_REPEAT;
                    end else begin
                        rcnt_d[k] = rcnt_q[k] + RCNT_W'(1);
                    end
                end
                ST_REPEAT: begin
                    if (accept_c[k]) begin
                        release_d[k] = 1'b1;
                        rcnt_d[k]    = '0;
                        state_d[k]   = ST_IDLE;
                    end else if (rcnt_q[k] == RP_LAST) begin
                        repeat_d[k] = 1'b1;
                        rcnt_d[k]   = '0;
                    end else begin
                        rcnt_d[k] = rcnt_q[k] + RCNT_W'(1);
                    end
                end
                default: begin
                    rcnt_d[k]  = '0;
                    state_d[k] = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_debounce_repeat.sv
// tb_key_debounce_repeat: randomized and directed stimulus for key_debounce_repeat,
// with a behavioural model pushing expected per-cycle outputs into a scoreboard
// queue and a negedge monitor popping and comparing.
module tb_key_debounce_repeat;

    localparam int unsigned N   = 4;
    localparam int unsigned DEB = 4;
    localparam int unsigned RD  = 10;
    localparam int unsigned RP  = 3;

    logic CLOCK_50 = 1'b0;
    logic RESET_N  = 1'b0;

    key_debounce_repeat_if #(.N_KEYS(N)) kif ();

    key_debounce_repeat #(
        .N_KEYS          (N),
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .kif      (kif)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int total = 0;
    int bad   = 0;

    typedef logic [4*N-1:0] exp_t;
    exp_t exp_q[$];

    // Model state: raw samples waiting in the two-deep synchronizer, the
    // accepted raw level, the run length of disagreeing samples, and the
    // cycle of the current press (repeats are derived arithmetically from it).
    int     dly0   [N];
    int     dly1   [N];
    int     m_raw  [N];
    int     run    [N];
    bit     held   [N];
    longint t_press[N];
    longint cyc;

    function automatic void model_reset();
        for (int k = 0; k < N; k++) begin
            dly0[k]    = 1;
            dly1[k]    = 1;
            m_raw[k]   = 1;
            run[k]     = 0;
            held[k]    = 1'b0;
            t_press[k] = 0;
        end
        cyc = 0;
    endfunction

    function automatic exp_t model_step();
        logic [N-1:0] lv, pr, rl, rp;
        int     d;
        longint el;
        lv = '0; pr = '0; rl = '0; rp = '0;
        cyc++;
        for (int k = 0; k < N; k++) begin
            d       = dly0[k];
            dly0[k] = dly1[k];
            dly1[k] = (kif.KEY[k] === 1'b0) ? 0 : 1;
            if (d != m_raw[k]) run[k]++;
            else               run[k] = 0;
            if (run[k] == int'(DEB)) begin
                run[k]   = 0;
                m_raw[k] = d;
                if (d == 0) begin
                    pr[k]      = 1'b1;
                    held[k]    = 1'b1;
                    t_press[k] = cyc;
                end else begin
                    rl[k]   = 1'b1;
                    held[k] = 1'b0;
                end
            end else if (held[k]) begin
                el = cyc - t_press[k];
                if (el == longint'(RD) || (el > longint'(RD) && ((el - longint'(RD)) % longint'(RP)) == 0))
                    rp[k] = 1'b1;
            end
            lv[k] = (m_raw[k] == 0);
        end
        return {lv, pr, rl, rp};
    endfunction

    // Reference model: one expected output vector per active edge.
    initial begin
        model_reset();
        forever begin
            @(posedge CLOCK_50 or negedge RESET_N);
            if (!RESET_N) begin
                model_reset();
                exp_q.delete();
            end else begin
                exp_q.push_back(model_step());
            end
        end
    end

    function automatic exp_t dut_outs();
        return {kif.KEY_LEVEL, kif.KEY_PRESS, kif.KEY_RELEASE, kif.KEY_REPEAT};
    endfunction

    // Monitor: compare away from the active edge.
    initial begin
        exp_t e;
        exp_t g;
        forever begin
            @(negedge CLOCK_50);
            g = dut_outs();
            if (!RESET_N) begin
                total++;
                if (g !== '0) begin
                    bad++;
                    $display("FAIL reset_outputs t=%0t got=%h exp=%h", $time, g, exp_t'(0));
                end
            end else if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (g !== e) begin
                    bad++;
                    $display("FAIL outputs t=%0t got=%h exp=%h (level|press|release|repeat)", $time, g, e);
                end
            end
        end
    end

    initial begin
        #200_000;
        $display("FAIL watchdog t=%0t simulation did not finish", $time);
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic hold_key(input int k, input int n);
        kif.KEY[k] = 1'b0;
        idle(n);
        kif.KEY[k] = 1'b1;
    endtask

    int rem[N];

    initial begin
        kif.KEY = '1;
        idle(3);
        #2 RESET_N = 1'b1;
        idle(10);

        // Clean press on key 0.
        hold_key(0, 15);
        idle(12);

        // Bounce on key 1, then held.
        for (int i = 0; i < 12; i++) begin
            kif.KEY[1] = (i % 2 == 0) ? 1'b0 : 1'b1;
            idle(1);
        end
        hold_key(1, 20);
        idle(12);

        // Auto-repeat on key 2: long hold, then release landing on a period boundary.
        hold_key(2, 35);
        idle(12);
        hold_key(2, 28);
        idle(12);

        // Short glitch on key 3.
        hold_key(3, 3);
        idle(12);

        // Simultaneous keys 0 and 3.
        kif.KEY[0] = 1'b0;
        kif.KEY[3] = 1'b0;
        idle(25);
        kif.KEY[0] = 1'b1;
        kif.KEY[3] = 1'b1;
        idle(12);

        // Reset while key 0 is in repeat; key still held across deassertion.
        kif.KEY[0] = 1'b0;
        idle(25);
        @(posedge CLOCK_50);
        #3 RESET_N = 1'b0;
        #1;
        total++;
        if (dut_outs() !== '0) begin
            bad++;
            $display("FAIL async_reset t=%0t got=%h exp=%h", $time, dut_outs(), exp_t'(0));
        end
        idle(3);
        #2 RESET_N = 1'b1;
        idle(25);
        kif.KEY[0] = 1'b1;
        idle(12);

        // Random independent activity on all keys.
        for (int k = 0; k < N; k++) rem[k] = 0;
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < N; k++) begin
                if (rem[k] == 0) begin
                    kif.KEY[k] = ~kif.KEY[k];
                    rem[k]     = int'($urandom_range(1, 30));
                end
                rem[k]--;
            end
            idle(1);
        end
        kif.KEY = '1;
        idle(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
